// File: rtl/ram_loader.sv
// Write-side loader for the on-board RAM: streams bytes into consecutive
// addresses, checks a trailing checksum, then read-back verifies the whole RAM.
module ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clke,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_byte,
    output logic                  o_ready,
    output logic                  o_re,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_csum,
    output logic                  o_err_verify
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Modular byte sum used by both the write-side and verify-side checksums.
    function automatic logic [DATA_WIDTH-1:0] csum_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        csum_add = a + b;
    endfunction

    function automatic logic is_last(input logic [ADDR_WIDTH-1:0] a);
        is_last = (a == ADDR_LAST);
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   wsum_q, wsum_d;
    logic [DATA_WIDTH-1:0]   vsum_q, vsum_d;
    logic                    err_csum_q, err_csum_d;
    logic                    err_verify_q, err_verify_d;
    logic                    ready_q, ready_d;
    logic                    re_q, re_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   csum_total_s;
    logic [DATA_WIDTH-1:0]   vsum_next_s;

    assign accept_s     = i_clke & i_valid & ready_q;
    assign csum_total_s = csum_add(wsum_q, i_byte);
    assign vsum_next_s  = csum_add(vsum_q, i_rdata);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; nothing advances on edges with the clock enable low.
    always_comb begin
        state_d = state_q;
        if (i_clke) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_RECV;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
                ST_WRITE: begin
                    if (is_last(addr_q)) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
                ST_CHECK: begin
                    if (accept_s) begin
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_VERIFY: begin
                    if (is_last(addr_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode from the next state so every status output is a flop.
    always_comb begin
        ready_d = 1'b0;
        re_d    = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE:   busy_d  = 1'b0;
            ST_RECV:   ready_d = 1'b1;
            ST_WRITE:  we_d    = 1'b1;
            ST_CHECK:  ready_d = 1'b1;
            ST_VERIFY: re_d    = 1'b1;
            ST_DONE:   done_d  = 1'b1;
            default:   busy_d  = 1'b0;
        endcase
    end

    // Datapath next values: address sweep, write data, running sums, error flags.
    always_comb begin
        addr_d       = addr_q;
        data_d       = data_q;
        wsum_d       = wsum_q;
        vsum_d       = vsum_q;
        err_csum_d   = err_csum_q;
        err_verify_d = err_verify_q;
        if (i_clke) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_d       = ADDR_ZERO;
                        wsum_d       = DATA_ZERO;
                        vsum_d       = DATA_ZERO;
                        err_csum_d   = 1'b0;
                        err_verify_d = 1'b0;
                    end else begin
                        addr_d = addr_q;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        data_d = i_byte;
                        wsum_d = csum_total_s;
                    end else begin
                        data_d = data_q;
                    end
                end
                ST_WRITE: begin
                    if (is_last(addr_q)) begin
                        addr_d = ADDR_ZERO;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                ST_CHECK: begin
                    if (accept_s) begin
                        err_csum_d = (csum_total_s != DATA_ZERO);
                    end else begin
                        err_csum_d = err_csum_q;
                    end
                end
                ST_VERIFY: begin
                    vsum_d = vsum_next_s;
                    if (is_last(addr_q)) begin
                        addr_d       = ADDR_ZERO;
                        err_verify_d = (vsum_next_s != wsum_q);
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                ST_DONE: begin
                    addr_d = addr_q;
                end
                default: begin
                    addr_d = ADDR_ZERO;
                end
            endcase
        end else begin
            addr_d = addr_q;
        end
    end

    // Datapath and output flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q       <= ADDR_ZERO;
            data_q       <= DATA_ZERO;
            wsum_q       <= DATA_ZERO;
            vsum_q       <= DATA_ZERO;
            err_csum_q   <= 1'b0;
            err_verify_q <= 1'b0;
            ready_q      <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            wsum_q       <= wsum_d;
            vsum_q       <= vsum_d;
            err_csum_q   <= err_csum_d;
            err_verify_q <= err_verify_d;
            ready_q      <= ready_d;
            re_q         <= re_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_re         = re_q;
    assign o_we         = we_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err_csum   = err_csum_q;
    assign o_err_verify = err_verify_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader with a behavioural 16x8 RAM.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clke = 1'b1;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       ready, re, we, busy, done, err_csum, err_verify;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       fault_en = 1'b0;

    logic [7:0] mem [16];
    logic [3:0] we_addr [512];
    logic [7:0] we_data [512];
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_clke(clke), .i_start(start),
        .i_valid(valid), .i_byte(byte_in), .o_ready(ready), .o_re(re),
        .o_we(we), .o_addr(addr), .o_data(wdata), .i_rdata(rdata),
        .o_busy(busy), .o_done(done), .o_err_csum(err_csum),
        .o_err_verify(err_verify)
    );

    always #5 clk = ~clk;

    // RAM model; optionally corrupts the read of address 5.
    assign rdata = (fault_en && addr == 4'd5) ? 8'hFF : mem[addr];

    // RAM write port plus a log of every write and read strobe.
    always @(posedge clk) begin
        if (!rst && clke && we) begin
            mem[addr]       <= wdata;
            we_addr[we_cnt] <= addr;
            we_data[we_cnt] <= wdata;
            we_cnt          <= we_cnt + 1;
        end
        if (!rst && clke && re) begin
            re_cnt <= re_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_state", {busy, ready, err_csum, err_verify, addr},
              {1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall, input bit start_too);
        int         n;
        logic [3:0] a0;
        int         w0;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("ready_timeout", {31'd0, ready}, 32'd1);
        end else begin
            valid   = 1'b1;
            byte_in = b;
            start   = start_too;
            if (stall) begin
                clke = 1'b0;
                a0   = addr;
                w0   = we_cnt;
                repeat (3) @(negedge clk);
                check("stall_addr", {28'd0, addr}, {28'd0, a0});
                check("stall_we", we_cnt, w0);
                check("stall_ready", {31'd0, ready}, 32'd1);
                clke = 1'b1;
            end
            @(negedge clk);
            valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic send_data();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i + 1), 1'b0, 1'b0);
        end
    endtask

    task automatic wait_done(input logic exp_c, input logic exp_v, input bit pulse_start);
        int n;
        int r0;
        r0 = re_cnt;
        if (pulse_start) begin
            start = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
            check("verify_busy", {31'd0, busy}, 32'd1);
        end
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("err_csum", {31'd0, err_csum}, {31'd0, exp_c});
        check("err_verify", {31'd0, err_verify}, {31'd0, exp_v});
        check("verify_len", re_cnt - r0, 16);
        @(negedge clk);
        check("done_fall", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int wb;
        repeat (2) @(negedge clk);
        check("reset_outs", {ready, re, we, busy, done, err_csum, err_verify, addr, wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal load with i_start pulses in RECV and in VERIFY.
        wb = we_cnt;
        do_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i + 1), 1'b0, i == 3);
        end
        send_byte(8'h78, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b1);
        check("nom_we_cnt", we_cnt - wb, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("nom_wr%0d", i), {20'd0, we_addr[wb + i], we_data[wb + i]},
                  {20'd0, 4'(i), 8'(i + 1)});
        end

        // Bad checksum: verify still runs and passes.
        do_start();
        send_data();
        send_byte(8'h00, 1'b0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b0);

        // Verify fault at address 5; the start check clears the csum flag.
        do_start();
        send_data();
        fault_en = 1'b1;
        send_byte(8'h78, 1'b0, 1'b0);
        wait_done(1'b0, 1'b1, 1'b0);
        fault_en = 1'b0;

        // Clock-enable stall during RECV of byte 9.
        wb = we_cnt;
        do_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i + 1), i == 8, 1'b0);
        end
        send_byte(8'h78, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0);
        check("stall_we_cnt", we_cnt - wb, 16);
        check("stall_wr8", {20'd0, we_addr[wb + 8], we_data[wb + 8]}, {20'd0, 4'd8, 8'h09});

        // Reset after seven bytes have been written.
        wb = we_cnt;
        do_start();
        for (int i = 0; i < 7; i++) begin
            send_byte(8'h40 + 8'(i), 1'b0, 1'b0);
        end
        @(negedge clk);
        check("mid_we_cnt", we_cnt - wb, 7);
        rst = 1'b1;
        #1;
        check("mid_reset_outs", {ready, re, we, busy, done, err_csum, err_verify, addr, wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wb = we_cnt;
        do_start();
        send_data();
        send_byte(8'h78, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, 1'b0);
        check("restart_wr0", {20'd0, we_addr[wb], we_data[wb]}, {20'd0, 4'd0, 8'h01});
        check("restart_we_cnt", we_cnt - wb, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side initiator for the on-board RAM block; used to program RAM contents before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses, 0 through ADDR_SIZE-1.
- Checks a trailing checksum byte, then performs a read-back verify pass over the whole RAM.
- Drives the RAM's re/we/addr/data inputs; o_busy holds the CPU in halt while loading.

Parameters:
- DATA_WIDTH, 8, width of RAM data word and of stream bytes.
- ADDR_WIDTH, 4, width of RAM address; ADDR_SIZE = 1 << ADDR_WIDTH words are loaded.

Ports:
- i_clk  input  1  system clock, all state changes on posedge.
- i_rst  input  1  asynchronous, active-high reset.
- i_clke  input  1  clock enable; state advances only on edges where i_clke=1.
- i_start  input  1  begin a load session; sampled only in IDLE.
- i_valid  input  1  stream byte valid.
- i_byte  input  DATA_WIDTH  stream byte.
- o_ready  output  1  loader can accept a byte.
- o_re  output  1  RAM read enable.
- o_we  output  1  RAM write enable.
- o_addr  output  ADDR_WIDTH  RAM address.
- o_data  output  DATA_WIDTH  RAM write data.
- i_rdata  input  DATA_WIDTH  RAM read data; combinational from o_addr.
- o_busy  output  1  session in progress (state != IDLE).
- o_done  output  1  session complete, high while in DONE.
- o_err_csum  output  1  checksum mismatch, sticky until next accepted start.
- o_err_verify  output  1  read-back mismatch, sticky until next accepted start.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; o_addr=0, o_data=0, wsum=0, vsum=0.
  - o_ready, o_re, o_we, o_busy, o_done, o_err_csum, o_err_verify all 0.
- All registers hold when i_clke=0.
- Handshake: a byte is accepted on a posedge where i_clke & i_valid & o_ready. Never accepted when i_clke=0, even if o_ready=1.
- o_ready=1 only in RECV and CHECK. o_re=1 only in VERIFY. o_we=1 only in WRITE.
- All outputs derive from registered state; no combinational path from i_valid to any output.
- State transitions (each taken only on an i_clke=1 edge):
  - IDLE: on i_start → RECV; clear o_addr, wsum, vsum, o_err_csum, o_err_verify.
  - RECV: on accept → WRITE; o_data<=i_byte; wsum<=wsum+i_byte (mod 2^DATA_WIDTH).
  - WRITE: o_we=1, o_addr/o_data stable; the RAM captures on this edge.
    - If o_addr==ADDR_SIZE-1 → CHECK with o_addr<=0.
    - Else o_addr<=o_addr+1 → RECV.
  - CHECK: on accept of checksum byte c → VERIFY; o_err_csum <= ((wsum+c) mod 2^DATA_WIDTH) != 0.
  - VERIFY: vsum<=vsum+i_rdata.
    - If o_addr==ADDR_SIZE-1 → DONE, with o_err_verify <= (vsum+i_rdata) != wsum and o_addr<=0.
    - Else o_addr<=o_addr+1.
  - DONE: o_done=1; → IDLE on next i_clke edge.
- Throughput: max one data byte per 2 enabled cycles. Verify takes exactly ADDR_SIZE enabled cycles.
- A checksum error does not skip verify; both flags are reported independently.
- i_start outside IDLE is ignored. i_valid/i_byte outside RECV/CHECK are ignored; no byte is consumed.
- Address wraps only via the explicit reset to 0 at the end of the WRITE and VERIFY sweeps; no overflow past ADDR_SIZE-1.
- Reset mid-session: immediate return to IDLE with all outputs 0. RAM keeps any partially written contents. The next i_start restarts at address 0.

Test Plan:
- Nominal (8/4), i_clke=1: start, bytes 0x01..0x10 then checksum 0x78 → 16 o_we pulses at addr 0..15 with data 0x01..0x10; o_err_csum=0; o_err_verify=0; o_done high 1 cycle; o_busy falls with DONE→IDLE.
- Bad checksum: same data, checksum 0x00 → o_err_csum=1, verify still runs, o_err_verify=0; next start clears o_err_csum.
- Verify fault: bench RAM model returns 0xFF at addr 5 during VERIFY → o_err_verify=1, o_err_csum=0.
- Clock enable stall: i_clke=0 for 3 cycles while i_valid=1 in RECV → no accept, o_addr unchanged, no extra o_we; resumes when i_clke=1.
- Reset mid-load: assert i_rst after 7 bytes written → all outputs 0 asynchronously; new session writes the first byte at addr 0.
- Start while busy: pulse i_start in RECV and in VERIFY → no state change, addresses and sums unaffected.
